// File: rtl/shift_register_seq_pkg.sv
// shift_register_seq_pkg: shared sequencer state type and rotation-count width helper
// No ports. Provides seq_state_t and rot_w().
package shift_register_seq_pkg;

    typedef enum logic {IDLE, EMIT} seq_state_t;

    function automatic int rot_w(input int max_rot);
        return $clog2(max_rot + 1);
    endfunction

endpackage

// File: rtl/shift_register_sequencer_rotate_bank.sv
// rotate_bank: circular register bank with parallel load and one-step rotation toward higher index
// Ports: clk, rst_n (async active-low), load/load_data (parallel load, wins over rotate),
//        rotate (bank[i] <= bank[i-1], bank[0] <= bank[last]), bank (current contents)
module rotate_bank #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data [BUFFER_SIZE],
    input  logic             rotate,
    output logic [WIDTH-1:0] bank      [BUFFER_SIZE]
);

    logic [WIDTH-1:0] r_bank [BUFFER_SIZE];
    logic [WIDTH-1:0] w_prev [BUFFER_SIZE];

    for (genvar g = 0; g < BUFFER_SIZE; g++) begin : g_prev
        assign w_prev[g] = r_bank[(g + BUFFER_SIZE - 1) % BUFFER_SIZE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bank <= '{default: '0};
        else if (load)
            r_bank <= load_data;
        else if (rotate)
            r_bank <= w_prev;
    end

    assign bank = r_bank;

endmodule

// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer: loads a vector, then emits every cyclic shift step 0..n-1 under valid/ready
// Ports: clk, rst_n (async active-low); input side data_in/cfg_num_rot/data_in_valid/data_in_ready;
//        output side data_out/data_out_valid/data_out_ready/rot_index/last; busy = transaction in flight
module shift_register_sequencer
    import shift_register_seq_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int BUFFER_SIZE = 16,
    parameter  int MAX_ROT     = 16,
    localparam int ROT_W       = rot_w(MAX_ROT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in  [BUFFER_SIZE],
    input  logic [ROT_W-1:0] cfg_num_rot,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [WIDTH-1:0] data_out [BUFFER_SIZE],
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic [ROT_W-1:0] rot_index,
    output logic             last,
    output logic             busy
);

    seq_state_t       r_state, w_state_next;
    logic [ROT_W-1:0] r_k, r_n, w_n_clamp;
    logic             w_in_fire, w_out_fire, w_rotate;

    // Zero means "emit once unrotated"; oversize counts saturate at MAX_ROT.
    assign w_n_clamp = (cfg_num_rot == '0)              ? ROT_W'(1) :
                       (cfg_num_rot > ROT_W'(MAX_ROT)) ? ROT_W'(MAX_ROT) : cfg_num_rot;

    always_comb begin
        w_state_next   = r_state;
        data_in_ready  = (r_state == IDLE);
        data_out_valid = (r_state == EMIT);
        busy           = (r_state == EMIT);
        last           = (r_state == EMIT) && (r_k == r_n - ROT_W'(1));
        w_in_fire      = data_in_ready && data_in_valid;
        w_out_fire     = data_out_valid && data_out_ready;
        if (w_in_fire)
            w_state_next = EMIT;
        else if (w_out_fire && last)
            w_state_next = IDLE;
    end

    // The final step leaves the bank as emitted rather than rotating past it.
    assign w_rotate  = w_out_fire && !last;
    assign rot_index = r_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
            r_n <= '0;
        end else if (w_in_fire) begin
            r_k <= '0;
            r_n <= w_n_clamp;
        end else if (w_rotate) begin
            r_k <= r_k + ROT_W'(1);
        end
    end

    rotate_bank #(
        .WIDTH       (WIDTH),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_in_fire),
        .load_data (data_in),
        .rotate    (w_rotate),
        .bank      (data_out)
    );

endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb_shift_register_sequencer: scoreboard bench for shift_register_sequencer
module tb_shift_register_sequencer;
    import shift_register_seq_pkg::*;

    localparam int W  = 8;
    localparam int BS = 16;
    localparam int MR = 20;
    localparam int RW = rot_w(MR);

    typedef struct {
        logic [W*BS-1:0] d;
        logic [RW-1:0]   k;
        logic            l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_in [BS];
    logic [RW-1:0] cfg_num_rot = '0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [W-1:0]  data_out [BS];
    logic          data_out_valid;
    logic          data_out_ready = 1'b1;
    logic [RW-1:0] rot_index;
    logic          last;
    logic          busy;

    beat_t        q[$];
    logic [W-1:0] v [BS];
    int vecs = 0, errs = 0, cyc = 0, last_hs = -10, lasts = 0, exp_lasts = 0;
    int rmode = 0, pi = 0, acc = 0, acc2 = 0;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};

    shift_register_sequencer #(
        .WIDTH       (W),
        .BUFFER_SIZE (BS),
        .MAX_ROT     (MR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .cfg_num_rot    (cfg_num_rot),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .rot_index      (rot_index),
        .last           (last),
        .busy           (busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [W*BS-1:0] pk(input logic [W-1:0] a [BS]);
        logic [W*BS-1:0] r;
        for (int i = 0; i < BS; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W*BS-1:0] act, input logic [W*BS-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected beats come from the index formula out[i] = in[(i-k) mod BS].
    task automatic send(input logic [W-1:0] vin [BS], input int c, output int accepted);
        int    n;
        beat_t b;
        n = (c == 0) ? 1 : (c > MR ? MR : c);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < BS; i++) b.d[i*W +: W] = vin[(((i - k) % BS) + BS) % BS];
            b.k = RW'(k);
            b.l = (k == n - 1);
            q.push_back(b);
        end
        exp_lasts++;
        @(posedge clk);
        #1;
        data_in       = vin;
        cfg_num_rot   = RW'(c);
        data_in_valid = 1'b1;
        accepted      = -1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (data_in_ready) begin
                accepted = cyc;
                break;
            end
        end
        if (accepted < 0) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 data_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((q.size() != 0 || busy) && t < 2000);
        if (t >= 2000) chk("drain_timeout", 0, 1);
    endtask

    // Ready generator: always high, fixed stall pattern, or random.
    initial forever begin
        @(posedge clk);
        #1;
        if (rmode == 0)
            data_out_ready = 1'b1;
        else if (rmode == 1) begin
            data_out_ready = pat[pi];
            pi = (pi + 1) % 6;
        end else
            data_out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: every valid cycle must match the head beat; pop on handshake.
    initial forever begin
        @(negedge clk);
        if (rst_n && data_out_valid) begin
            if (q.size() == 0)
                chk("unexpected_beat", 1, 0);
            else begin
                chk("data_out", pk(data_out), q[0].d);
                chk("rot_index", rot_index, q[0].k);
                chk("last", last, q[0].l);
                if (data_out_ready) begin
                    if (last) begin
                        lasts++;
                        last_hs = cyc;
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < BS; i++) data_in[i] = '0;
        #12;
        chk("rst_in_ready", data_in_ready, 1);
        chk("rst_out_valid", data_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", last, 0);
        chk("rst_rot_index", rot_index, 0);
        chk("rst_data_out", pk(data_out), 0);
        @(negedge clk) rst_n = 1'b1;
        // basic rotation, n=4
        for (int i = 0; i < BS; i++) v[i] = W'(i);
        send(v, 4, acc);
        drain();
        chk("idle_cycle_after_last", cyc, last_hs + 1);
        chk("ready_after_last", data_in_ready, 1);
        // backpressure, n=3
        rmode = 1;
        pi = 0;
        for (int i = 0; i < BS; i++) v[i] = W'(i * 3 + 1);
        send(v, 3, acc);
        drain();
        rmode = 0;
        // wrap past BUFFER_SIZE, zero clamp, MAX_ROT clamp
        for (int i = 0; i < BS; i++) v[i] = W'(8'hA0 + i);
        send(v, 17, acc);
        drain();
        for (int i = 0; i < BS; i++) v[i] = W'(8'h55 ^ i);
        send(v, 0, acc);
        drain();
        for (int i = 0; i < BS; i++) v[i] = W'(8'hF0 - i);
        send(v, 25, acc);
        drain();
        // second vector held pending during a transaction
        for (int i = 0; i < BS; i++) v[i] = W'(8'h10 + i);
        send(v, 4, acc);
        for (int i = 0; i < BS; i++) v[i] = W'(8'hC3 + 7 * i);
        send(v, 3, acc2);
        chk("pending_accept_cycle", acc2, last_hs + 1);
        drain();
        // asynchronous reset at k=2 of n=8
        for (int i = 0; i < BS; i++) v[i] = W'(8'h21 * i + 5);
        send(v, 8, acc);
        acc = 0;
        while (!(data_out_valid && rot_index == 2) && acc < 100) begin
            @(negedge clk);
            acc++;
        end
        if (acc >= 100) chk("reach_k2_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", data_out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data_out", pk(data_out), 0);
        chk("midrst_rot_index", rot_index, 0);
        q.delete();
        exp_lasts--;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("post_rst_in_ready", data_in_ready, 1);
        for (int i = 0; i < BS; i++) v[i] = W'(8'h3C + i);
        send(v, 5, acc);
        drain();
        // back-to-back random traffic
        rmode = 2;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < BS; i++) v[i] = W'($urandom);
            send(v, int'($urandom_range(0, 24)), acc);
        end
        drain();
        rmode = 0;
        chk("last_count", lasts, exp_lasts);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
